// File: rtl/ram_block_mover.sv
// ram_block_mover: command-driven master for a 256x32 dual-port RAM.
// Executes block copy (read port 1, write port 2, one word per beat) and
// block fill (pattern on both ports, two words per beat). Addresses wrap mod 256.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid / cmd_ready      command handshake (ready only in idle)
//   cmd_mode                   0 = copy, 1 = fill
//   cmd_src, cmd_dst, cmd_len  source base, destination base, word count (0 = no-op)
//   cmd_pat                    fill pattern
//   abort                      drop the active command without a done pulse
//   busy, done                 command in progress / one-cycle completion pulse
//   en1/addr1/din1, en2/addr2/din2   RAM port write enable, address, write data
//   dout1, dout2               RAM read data, combinational from addr1/addr2
//
// Build option: define RAM_MOVER_WR_HOLD_EN to hold every beat for two cycles.
module ram_block_mover (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_mode,
  input  logic [7:0]  cmd_src,
  input  logic [7:0]  cmd_dst,
  input  logic [7:0]  cmd_len,
  input  logic [31:0] cmd_pat,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        en1,
  output logic        en2,
  output logic [7:0]  addr1,
  output logic [7:0]  addr2,
  output logic [31:0] din1,
  output logic [31:0] din2,
  input  logic [31:0] dout1,
  input  logic [31:0] dout2
);

`ifdef RAM_MOVER_WR_HOLD_EN
  localparam logic HoldEn = 1'b1;
`else
  localparam logic HoldEn = 1'b0;
`endif

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCopy = 2'd1;
  localparam logic [1:0] StFill = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        mode_q, mode_d;
  logic [7:0]  src_q, src_d, dst_q, dst_d, len_q, len_d, beat_q, beat_d;
  logic [31:0] pat_q, pat_d;
  logic        phase_q, phase_d;
  logic        en1_q, en1_d, en2_q, en2_d, busy_q, busy_d, done_q, done_d;
  logic [7:0]  addr1_q, addr1_d, addr2_q, addr2_d;
  logic [31:0] din1_q, din1_d, din2_q, din2_d;

  logic [8:0]  fill_beats;
  logic [7:0]  nbeats, next_beat, fill_off;
  logic        fill_en2_next, advance, copy_live;

  // Port 2 read data is not needed by either command.
  logic unused_dout2;
  assign unused_dout2 = ^dout2;

  assign fill_beats    = ({1'b0, len_q} + 9'd1) >> 1;
  assign nbeats        = mode_q ? fill_beats[7:0] : len_q;
  assign next_beat     = beat_q + 8'd1;
  assign fill_off      = {next_beat[6:0], 1'b0};
  assign fill_en2_next = ({1'b0, fill_off} + 9'd1) < {1'b0, len_q};
  // In hold mode a beat advances only after its second cycle.
  assign advance       = !HoldEn || phase_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    pat_d   = pat_q;
    beat_d  = beat_q;
    phase_d = phase_q;
    en1_d   = en1_q;
    en2_d   = en2_q;
    addr1_d = addr1_q;
    addr2_d = addr2_q;
    din1_d  = din1_q;
    din2_d  = din2_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        en1_d = 1'b0;
        en2_d = 1'b0;
        if (cmd_valid) begin
          mode_d  = cmd_mode;
          src_d   = cmd_src;
          dst_d   = cmd_dst;
          len_d   = cmd_len;
          pat_d   = cmd_pat;
          beat_d  = 8'd0;
          phase_d = 1'b0;
          if (cmd_len == 8'd0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else if (!cmd_mode) begin
            state_d = StCopy;
            busy_d  = 1'b1;
            addr1_d = cmd_src;
            en2_d   = 1'b1;
            addr2_d = cmd_dst;
          end else begin
            state_d = StFill;
            busy_d  = 1'b1;
            en1_d   = 1'b1;
            addr1_d = cmd_dst;
            din1_d  = cmd_pat;
            if (cmd_len > 8'd1) begin
              en2_d   = 1'b1;
              addr2_d = cmd_dst + 8'd1;
              din2_d  = cmd_pat;
            end
          end
        end
      end
      StCopy, StFill: begin
        // Copy write data is the live read; keep a copy so din2 holds afterwards.
        if (copy_live) din2_d = dout1;
        if (abort) begin
          state_d = StIdle;
          en1_d   = 1'b0;
          en2_d   = 1'b0;
          phase_d = 1'b0;
        end else if (!advance) begin
          phase_d = 1'b1;
          busy_d  = 1'b1;
        end else if (beat_q == nbeats - 8'd1) begin
          state_d = StDone;
          done_d  = 1'b1;
          en1_d   = 1'b0;
          en2_d   = 1'b0;
          phase_d = 1'b0;
        end else begin
          beat_d  = next_beat;
          phase_d = 1'b0;
          busy_d  = 1'b1;
          if (state_q == StCopy) begin
            addr1_d = src_q + next_beat;
            addr2_d = dst_q + next_beat;
          end else begin
            addr1_d = dst_q + fill_off;
            din1_d  = pat_q;
            en2_d   = fill_en2_next;
            if (fill_en2_next) begin
              addr2_d = dst_q + fill_off + 8'd1;
              din2_d  = pat_q;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      src_q   <= 8'd0;
      dst_q   <= 8'd0;
      len_q   <= 8'd0;
      pat_q   <= 32'd0;
      beat_q  <= 8'd0;
      phase_q <= 1'b0;
      en1_q   <= 1'b0;
      en2_q   <= 1'b0;
      addr1_q <= 8'd0;
      addr2_q <= 8'd0;
      din1_q  <= 32'd0;
      din2_q  <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      beat_q  <= beat_d;
      phase_q <= phase_d;
      en1_q   <= en1_d;
      en2_q   <= en2_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      din1_q  <= din1_d;
      din2_q  <= din2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Copy forwards dout1 within the beat so a read sees the previous beat's write;
  // in hold mode the second cycle uses the value captured in the first.
  assign copy_live = (state_q == StCopy) && !phase_q;

  assign cmd_ready = (state_q == StIdle);
  assign busy      = busy_q;
  assign done      = done_q;
  assign en1       = en1_q;
  assign en2       = en2_q;
  assign addr1     = addr1_q;
  assign addr2     = addr2_q;
  assign din1      = din1_q;
  assign din2      = copy_live ? dout1 : din2_q;

endmodule

// File: tb/tb_ram_block_mover.sv
// Scoreboard bench for ram_block_mover with a behavioural 256x32 dual-port RAM.
module tb_ram_block_mover;

`ifdef RAM_MOVER_WR_HOLD_EN
  localparam int H = 2;
`else
  localparam int H = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_mode, abort, busy, done, en1, en2;
  logic [7:0]  cmd_src, cmd_dst, cmd_len, addr1, addr2;
  logic [31:0] cmd_pat, din1, din2, dout1, dout2;

  logic [31:0] mem [256];
  logic        pre_init, pre_we;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;

  int          cyc = 0;
  int          t_acc;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [40:0] exp_wr[$];   // {port(0=port1,1=port2), addr, data}
  int          exp_done[$]; // cycle in which done must be high

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_block_mover dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .cmd_pat(cmd_pat), .abort(abort), .busy(busy), .done(done),
    .en1(en1), .en2(en2), .addr1(addr1), .addr2(addr2), .din1(din1), .din2(din2),
    .dout1(dout1), .dout2(dout2)
  );

  // RAM model: synchronous write, combinational read.
  always @(posedge clk) begin
    if (pre_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 | i;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else begin
      if (en1) mem[addr1] <= din1;
      if (en2) mem[addr2] <= din2;
    end
  end
  assign dout1 = mem[addr1];
  assign dout2 = mem[addr2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write and every done pulse must match the scoreboard head.
  always @(negedge clk) begin
    logic [40:0] e;
    if (en1 === 1'b1) begin
      if (exp_wr.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL wr1_unexpected: got addr %0h data %0h expected no write", addr1, din1);
      end else begin
        e = exp_wr.pop_front();
        chk("wr1", {1'b0, addr1, din1}, e);
      end
    end
    if (en2 === 1'b1) begin
      if (exp_wr.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL wr2_unexpected: got addr %0h data %0h expected no write", addr2, din2);
      end else begin
        e = exp_wr.pop_front();
        chk("wr2", {1'b1, addr2, din2}, e);
      end
    end
    if (done === 1'b1) begin
      if (exp_done.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL done_unexpected: got done at cycle %0d expected none", cyc);
      end else begin
        chk("done_cycle", cyc, exp_done.pop_front());
        chk("done_busy", busy, 1'b0);
      end
    end
  end

  // One beat as seen on the ports; repeated H times in hold mode.
  task automatic push_beat(input logic w1, input logic [7:0] a1, input logic [31:0] d1,
                           input logic w2, input logic [7:0] a2, input logic [31:0] d2);
    for (int h = 0; h < H; h++) begin
      if (w1) exp_wr.push_back({1'b0, a1, d1});
      if (w2) exp_wr.push_back({1'b1, a2, d2});
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Called 1 time unit after a posedge with the engine idle; accepted at the next edge.
  task automatic issue(input logic m, input logic [7:0] s, input logic [7:0] d,
                       input logic [7:0] l, input logic [31:0] p);
    cmd_mode = m; cmd_src = s; cmd_dst = d; cmd_len = l; cmd_pat = p;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    t_acc = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_wait", cmd_ready, 1'b1);
    chk("sb_wr_empty", exp_wr.size(), 0);
    chk("sb_done_empty", exp_done.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_src = 8'd0; cmd_dst = 8'd0;
    cmd_len = 8'd0; cmd_pat = 32'd0; abort = 1'b0;
    pre_init = 1'b0; pre_we = 1'b0; pre_addr = 8'd0; pre_data = 32'd0;
    repeat (2) @(posedge clk); #1;
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_busy_done", {busy, done}, 2'b00);
    chk("rst_en", {en1, en2}, 2'b00);
    chk("rst_addr", {addr1, addr2}, 16'h0);
    chk("rst_din", {din1, din2}, 64'h0);
    @(negedge clk) rst_n = 1'b1; pre_init = 1'b1;
    @(posedge clk); #1 pre_init = 1'b0;
    for (int k = 0; k < 4; k++) preload(8'h10 + 8'(k), 32'hA0 + k);
    preload(8'h20, 32'h5);

    // Block copy 0x10 -> 0x40, 4 words.
    for (int k = 0; k < 4; k++) push_beat(1'b0, 8'h0, 32'h0, 1'b1, 8'h40 + 8'(k), 32'hA0 + k);
    issue(1'b0, 8'h10, 8'h40, 8'd4, 32'h0);
    exp_done.push_back(t_acc + 4 * H);
    wait_idle();
    for (int k = 0; k < 4; k++) chk("copy_mem", mem[8'h40 + 8'(k)], 32'hA0 + k);

    // Odd fill with wrap at 0xFE, len 3.
    push_beat(1'b1, 8'hFE, 32'hDEADBEEF, 1'b1, 8'hFF, 32'hDEADBEEF);
    push_beat(1'b1, 8'h00, 32'hDEADBEEF, 1'b0, 8'h0, 32'h0);
    issue(1'b1, 8'h00, 8'hFE, 8'd3, 32'hDEADBEEF);
    exp_done.push_back(t_acc + 2 * H);
    repeat (H) @(posedge clk); #1;
    chk("fill_last_en", {en1, en2}, 2'b10);
    wait_idle();
    chk("fill_mem_fe", mem[8'hFE], 32'hDEADBEEF);
    chk("fill_mem_ff", mem[8'hFF], 32'hDEADBEEF);
    chk("fill_mem_00", mem[8'h00], 32'hDEADBEEF);
    chk("fill_mem_01", mem[8'h01], 32'h1000_0001);

    // Overlapping forward copy replicates mem[0x20].
    for (int k = 0; k < 3; k++) push_beat(1'b0, 8'h0, 32'h0, 1'b1, 8'h21 + 8'(k), 32'h5);
    issue(1'b0, 8'h20, 8'h21, 8'd3, 32'h0);
    exp_done.push_back(t_acc + 3 * H);
    wait_idle();
    for (int k = 0; k < 3; k++) chk("ovl_mem", mem[8'h21 + 8'(k)], 32'h5);

    // Zero length: done in the first cycle, nothing else moves.
    issue(1'b0, 8'h00, 8'h33, 8'd0, 32'h0);
    exp_done.push_back(t_acc);
    for (int k = 0; k < 3; k++) begin
      chk("len0_busy_en", {busy, en1, en2}, 3'b000);
      @(posedge clk); #1;
    end
    wait_idle();

    // Abort sampled at the edge that would start beat 2 of an 8-word copy.
    for (int k = 0; k < 2; k++)
      push_beat(1'b0, 8'h0, 32'h0, 1'b1, 8'h70 + 8'(k), 32'h1000_0060 + k);
    issue(1'b0, 8'h60, 8'h70, 8'd8, 32'h0);
    repeat (2 * H - 1) @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_ready", cmd_ready, 1'b1);
    chk("abort_busy_en", {busy, en1, en2}, 3'b000);
    repeat (4) @(posedge clk); #1;
    wait_idle();
    chk("abort_mem_70", mem[8'h70], 32'h1000_0060);
    chk("abort_mem_71", mem[8'h71], 32'h1000_0061);
    chk("abort_mem_72", mem[8'h72], 32'h1000_0072);

    // Full-length fill from 0x80 wraps around to 0x7E.
    for (int j = 0; j < 128; j++)
      push_beat(1'b1, 8'h80 + 8'(2 * j), 32'hCAFEF00D,
                j < 127, 8'h81 + 8'(2 * j), 32'hCAFEF00D);
    issue(1'b1, 8'h00, 8'h80, 8'd255, 32'hCAFEF00D);
    exp_done.push_back(t_acc + 128 * H);
    wait_idle();
    chk("big_mem_7e", mem[8'h7E], 32'hCAFEF00D);
    chk("big_mem_7f", mem[8'h7F], 32'h1000_007F);
    chk("big_mem_80", mem[8'h80], 32'hCAFEF00D);

    // Reset in the middle of a fill; only beat 0 lands.
    push_beat(1'b1, 8'h90, 32'h12345678, 1'b1, 8'h91, 32'h12345678);
    issue(1'b1, 8'h00, 8'h90, 8'd8, 32'h12345678);
    repeat (H) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_en", {en1, en2}, 2'b00);
    chk("rstmid_ready_busy_done", {cmd_ready, busy, done}, 3'b100);
    chk("rstmid_addr_din", {addr1, addr2, din1, din2}, 80'h0);
    chk("rstmid_sb", exp_wr.size(), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_mem_92", mem[8'h92], 32'hCAFEF00D);
    for (int k = 0; k < 2; k++)
      push_beat(1'b0, 8'h0, 32'h0, 1'b1, 8'hA0 + 8'(k), 32'h12345678);
    issue(1'b0, 8'h90, 8'hA0, 8'd2, 32'h0);
    exp_done.push_back(t_acc + 2 * H);
    wait_idle();
    chk("post_rst_mem_a0", mem[8'hA0], 32'h12345678);
    chk("post_rst_mem_a1", mem[8'hA1], 32'h12345678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
